switch_debouncer: RTL
=====================

# switch_debouncer

Conditions the raw slide-switch bus before it reaches the 4-bit greater-than comparator, which reads switches [7:4] and [3:0] as its two operands. Each raw switch input is synchronised to `clk` through two flops. The whole bus is debounced as one word, so both operands always update together and in the same cycle. The block emits a one-cycle `changed` pulse whenever a new stable value is committed.

## Interface
- `WIDTH`, default 8: switch bus width. The comparator needs 8.
- `STABLE_CYCLES`, default 1000000: consecutive identical synchronised samples required before commit; 10 ms at 100 MHz. Must be ≥ 1.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset; synchronous and active-low.
- `sw_raw`  in  WIDTH  asynchronous switch pins.
- `sw_stable`  out  WIDTH  debounced bus, registered. Drives the comparator `switch` input.
- `changed`  out  1  one-cycle pulse, registered, in the cycle `sw_stable` takes a new value.

## Operation
- **Synchroniser:** `sync1 <= sw_raw`, then `sync2 <= sync1`. All downstream logic uses only `sync2`.
- **Internal registers:**
  - `cand` [WIDTH]: candidate value.
  - `cnt`: counter, width $clog2(STABLE_CYCLES+1).
  - `state`: one of {IDLE, COUNTING}.
- **Reset:** while `n_rst`=0 at a rising edge, the following are cleared:
  - `sync1`, `sync2`, `cand`, `sw_stable` = 0;
  - `cnt` = 0, `changed` = 0, `state` = IDLE.
  - Reset overrides any count in progress. No commit or pulse occurs in the reset cycle.
- **IDLE:**
  - If `sync2` == `sw_stable`: stay, `cnt` = 0.
  - Otherwise: `cand` <= `sync2`, `cnt` <= 1, go to COUNTING.
- **COUNTING:** conditions are evaluated in this order.
  1. `sync2` == `sw_stable` (bounced back): go to IDLE, `cnt` <= 0, no pulse.
  2. `sync2` != `cand` (a different new value): `cand` <= `sync2`, `cnt` <= 1, stay.
  3. `cnt` == STABLE_CYCLES: `sw_stable` <= `cand`, `changed` <= 1, `cnt` <= 0, go to IDLE.
  4. Otherwise: `cnt` <= `cnt` + 1.
- **`changed`:** is 0 in every cycle except the commit cycle. It is never high in two consecutive cycles.
- **Whole-word behaviour:** any bit toggling restarts qualification for the whole word. Two switches moved a few cycles apart produce one commit, with the later timing.
- **Counter range:** the counter never exceeds STABLE_CYCLES, so it cannot wrap.

## Timing
- Edge 0 is the rising edge that first captures a new `sw_raw` into `sync1`, provided the value then stays constant.
  - Edge 1: `sync2` holds the new value.
  - Edge 2: `cand` is loaded and `cnt` = 1.
  - Edge STABLE_CYCLES+1: `cnt` = STABLE_CYCLES.
  - Edge STABLE_CYCLES+2: `sw_stable` updates and `changed` = 1 for exactly that one cycle.
- **Total latency:** STABLE_CYCLES+2 edges from sync capture to commit.
- **Minimum pulse rejected:** a raw glitch lasting fewer than STABLE_CYCLES+1 sampled cycles never reaches `sw_stable`.
- **Outputs:** both outputs come straight from flops; there is no combinational path from `sw_raw`.
- **Reset release:** with `sw_raw` held nonzero across reset release, the first commit occurs STABLE_CYCLES+2 edges after the first non-reset edge.

## Test plan
All scenarios use STABLE_CYCLES=4 and WIDTH=8.
- **Reset:** hold `n_rst`=0 for 3 edges with `sw_raw`=8'hFF. Required: `sw_stable`=8'h00 and `changed`=0 throughout. After release, commit of 8'hFF at the 6th edge with a one-cycle `changed`.
- **Clean change:** from stable 8'h00, set `sw_raw`=8'h53 (comparator 5>3) and hold. Required: `sw_stable`=8'h53 at edge 6 after sync capture, `changed` high for exactly 1 cycle, and no further pulses while the input is held.
- **Glitch rejection:** from stable 8'h53, drive 8'h35 for 3 cycles, then 8'h53 again. Required: `sw_stable` stays 8'h53 and `changed` never asserts.
- **Bounce restart:** from stable 8'h00, toggle `sw_raw` between 8'h10 and 8'h00 every 2 cycles ×4, then hold 8'h10. Required: a single commit of 8'h10 exactly 6 edges after the final transition is captured.
- **Candidate replacement:** from stable 8'h00, apply 8'h21, then 8'h12 two cycles later and hold. Required: 8'h21 is never output, and 8'h12 commits 6 edges after its capture.
- **Reset mid-count:** apply 8'hA5, then assert `n_rst`=0 at the edge where `cnt`=3. Required: `sw_stable`=8'h00 and `changed`=0. After release with 8'hA5 still held, a full 6-edge requalification before commit.

Source files
------------

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Conditions the raw slide-switch bus feeding the 4-bit greater-than
// comparator (operands are switches [7:4] and [3:0]). Each raw pin passes
// through a two-flop synchroniser. The synchronised word is then debounced as
// a whole, so both comparator operands always update together in one cycle.
//
// Ports:
//   clk        in   1      system clock
//   n_rst      in   1      synchronous, active-low reset
//   sw_raw     in   WIDTH  asynchronous switch pins
//   sw_stable  out  WIDTH  debounced bus (registered)
//   changed    out  1      one-cycle pulse (registered) when sw_stable updates
//
// Parameters:
//   WIDTH          switch bus width
//   STABLE_CYCLES  consecutive identical synchronised samples needed to
//                  commit a new value (must be >= 1)
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             changed
);

  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] cand_r;
  logic [WIDTH-1:0] sw_stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             changed_r;
  state_t           state_r;

  state_t           state_next_s;
  logic [WIDTH-1:0] cand_next_s;
  logic [WIDTH-1:0] stable_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             changed_next_s;

  // Two-flop synchroniser; only sync2_r is used downstream.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // State register plus the registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r     <= IDLE;
      cand_r      <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      sw_stable_r <= {WIDTH{1'b0}};
      changed_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cand_r      <= cand_next_s;
      cnt_r       <= cnt_next_s;
      sw_stable_r <= stable_next_s;
      changed_r   <= changed_next_s;
    end
  end

  // Next-state logic. In COUNTING the checks are prioritised: bounce back to
  // the committed value, then a new candidate, then qualification complete.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (sync2_r != sw_stable_r) begin
          state_next_s = COUNTING;
        end else begin
          state_next_s = IDLE;
        end
      end
      COUNTING: begin
        if (sync2_r == sw_stable_r) begin
          state_next_s = IDLE;
        end else if (sync2_r != cand_r) begin
          state_next_s = COUNTING;
        end else if (cnt_r == CNT_MAX) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = COUNTING;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath/output next values. Any bit change in the word restarts the
  // count, and the counter is cleared on commit so it never exceeds CNT_MAX.
  always_comb begin
    cand_next_s    = cand_r;
    cnt_next_s     = cnt_r;
    stable_next_s  = sw_stable_r;
    changed_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync2_r != sw_stable_r) begin
          cand_next_s = sync2_r;
          cnt_next_s  = CNT_ONE;
        end else begin
          cnt_next_s  = CNT_ZERO;
        end
      end
      COUNTING: begin
        if (sync2_r == sw_stable_r) begin
          cnt_next_s = CNT_ZERO;
        end else if (sync2_r != cand_r) begin
          cand_next_s = sync2_r;
          cnt_next_s  = CNT_ONE;
        end else if (cnt_r == CNT_MAX) begin
          stable_next_s  = cand_r;
          changed_next_s = 1'b1;
          cnt_next_s     = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_next_s = CNT_ZERO;
      end
    endcase
  end

  assign sw_stable = sw_stable_r;
  assign changed   = changed_r;

endmodule
